fetch_unit_redirect: RTL and testbench

//  In-order instruction fetch stage. It sits directly upstream of the

---
 rtl/fetch_unit_redirect.sv | 136 +++++++++++++
 tb/tb_fetch_unit_redirect.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_redirect.sv
// In-order fetch stage: pipelined I-mem requests, squash redirect with stale
// response dropping, and sequence-number tagging toward decode.
module fetch_unit_redirect #(
    parameter int          p_seq_num_bits  = 5,
    parameter int          p_max_in_flight = 4,
    parameter logic [31:0] p_reset_addr    = 32'h200
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [31:0]               mem_resp_data,
    output logic                      F_val,
    input  logic                      F_rdy,
    output logic [31:0]               F_inst,
    output logic [31:0]               F_pc,
    output logic [p_seq_num_bits-1:0] F_seq_num,
    input  logic                      squash_val,
    input  logic [31:0]               squash_target,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num
);

    localparam int                 SB       = p_seq_num_bits;
    localparam int                 CNT_W    = $clog2(p_max_in_flight + 1);
    localparam int                 PTR_W    = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(p_max_in_flight);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(p_max_in_flight - 1);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [SB-1:0]      SEQ_ONE  = SB'(1);
    localparam logic [SB-1:0]      SEQ_FULL = '1;

    logic [31:0]      pc;
    logic [31:0]      pc_fifo [p_max_in_flight];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] drop_cnt;
    logic [SB-1:0]    next_seq;
    logic [SB-1:0]    oldest_seq;
    logic             rst_q;

    logic             out_en;
    logic             drop_mode;
    logic             seq_avail;
    logic [SB-1:0]    outstanding;
    logic             req_xfer;
    logic             resp_xfer;
    logic             f_xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    // Valids stay low in the reset cycle and the one after it.
    assign out_en       = !rst && !rst_q;
    assign drop_mode    = (drop_cnt != '0);
    assign outstanding  = next_seq - oldest_seq;
    assign seq_avail    = (outstanding != SEQ_FULL);

    assign mem_req_val  = out_en && (in_flight < MAX_CNT);
    assign mem_req_addr = squash_val ? squash_target : pc;
    assign mem_resp_rdy = out_en && (drop_mode || (F_rdy && seq_avail && !squash_val));

    assign F_val        = out_en && !drop_mode && mem_resp_val && seq_avail && !squash_val;
    assign F_inst       = mem_resp_data;
    assign F_pc         = pc_fifo[head];
    assign F_seq_num    = next_seq;

    assign req_xfer     = mem_req_val && mem_req_rdy;
    assign resp_xfer    = mem_resp_val && mem_resp_rdy;
    assign f_xfer       = F_val && F_rdy;

    // NOTE: state registers use non-blocking assignments so every update in
    // this block reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            pc         <= p_reset_addr;
            head       <= '0;
            tail       <= '0;
            in_flight  <= '0;
            drop_cnt   <= '0;
            next_seq   <= '0;
            oldest_seq <= '0;
        end else begin
            if (req_xfer) begin
                tail <= ptr_inc(tail);
                pc   <= mem_req_addr + 32'd4;
            end else if (squash_val) begin
                pc <= squash_target;
            end

            if (resp_xfer)
                head <= ptr_inc(head);

            in_flight <= in_flight + CNT_W'(req_xfer) - CNT_W'(resp_xfer);

            // Everything older than this cycle's request becomes stale.
            if (squash_val)
                drop_cnt <= in_flight - CNT_W'(resp_xfer);
            else if (drop_mode && resp_xfer)
                drop_cnt <= drop_cnt - CNT_ONE;

            if (squash_val)
                next_seq <= squash_seq_num + SEQ_ONE;
            else if (f_xfer)
                next_seq <= next_seq + SEQ_ONE;

            if (commit_val)
                oldest_seq <= commit_seq_num + SEQ_ONE;
        end
    end

    // NOTE: the PC storage is intentionally not reset; an entry is only read
    // after in_flight shows it was written, so reset only has to clear pointers.
    always_ff @(posedge clk) begin
        if (req_xfer)
            pc_fifo[tail] <= mem_req_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_resp_val && in_flight == '0))
                else $error("fetch_unit_redirect: response with no request outstanding");
            assert (drop_cnt <= in_flight)
                else $error("fetch_unit_redirect: drop count exceeds in-flight count");
        end
    end

endmodule

// File: tb/tb_fetch_unit_redirect.sv
// Directed plus randomized bench for fetch_unit_redirect against a
// transaction-level model (queue of outstanding requests tagged stale/live).
module tb_fetch_unit_redirect;

    localparam int          SB       = 2;
    localparam int          SEQ_MOD  = 1 << SB;
    localparam int          MAXF     = 4;
    localparam logic [31:0] RST_ADDR = 32'h200;

    logic          clk;
    logic          rst;
    logic          mem_req_val;
    logic          mem_req_rdy;
    logic [31:0]   mem_req_addr;
    logic          mem_resp_val;
    logic          mem_resp_rdy;
    logic [31:0]   mem_resp_data;
    logic          F_val;
    logic          F_rdy;
    logic [31:0]   F_inst;
    logic [31:0]   F_pc;
    logic [SB-1:0] F_seq_num;
    logic          squash_val;
    logic [31:0]   squash_target;
    logic [SB-1:0] squash_seq_num;
    logic          commit_val;
    logic [SB-1:0] commit_seq_num;

    fetch_unit_redirect #(
        .p_seq_num_bits (SB),
        .p_max_in_flight(MAXF),
        .p_reset_addr   (RST_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_rdy  (mem_resp_rdy),
        .mem_resp_data (mem_resp_data),
        .F_val         (F_val),
        .F_rdy         (F_rdy),
        .F_inst        (F_inst),
        .F_pc          (F_pc),
        .F_seq_num     (F_seq_num),
        .squash_val    (squash_val),
        .squash_target (squash_target),
        .squash_seq_num(squash_seq_num),
        .commit_val    (commit_val),
        .commit_seq_num(commit_seq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Memory environment
    mreq_t mem_q[$];
    int    lat_lo, lat_hi, cyc;
    bit    mem_hold;

    // Reference model
    ent_t        m_q[$];
    logic [31:0] m_pc;
    int          m_next, m_oldest;
    bit          m_rst_q;
    int          cq[$];
    bit          auto_commit;
    int          commit_pct;
    int          dut_deliv, model_acc;

    // Samples taken mid-cycle
    logic          s_req_val, s_resp_rdy, s_f_val;
    logic [31:0]   s_req_addr, s_f_inst, s_f_pc;
    logic [SB-1:0] s_f_seq;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_ADDR;
        m_next   = 0;
        m_oldest = 0;
        m_q.delete();
        cq.delete();
    endtask

    // One clock: drive env, compare at negedge, advance env and model at posedge.
    task automatic cycle();
        bit          out_en, dropping, avail, e_req_val, e_resp_rdy, e_f_val;
        bit          auto_c, req_x, resp_x, f_x;
        logic [31:0] e_req_addr;
        int          r;

        auto_c = 0;
        if (auto_commit) begin
            commit_val = 1'b0;
            if (!rst && cq.size() > 0 && $urandom_range(99) < commit_pct) begin
                commit_val     = 1'b1;
                commit_seq_num = SB'(cq[0]);
                auto_c         = 1;
            end
        end
        if (!mem_hold && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = inst_of(mem_q[0].addr);
        end else begin
            mem_resp_val  = 1'b0;
            mem_resp_data = 32'h0;
        end

        out_en     = !rst && !m_rst_q;
        dropping   = (m_q.size() > 0) && m_q[0].stale;
        avail      = ((m_next - m_oldest) & (SEQ_MOD - 1)) != (SEQ_MOD - 1);
        e_req_val  = out_en && (m_q.size() < MAXF);
        e_req_addr = squash_val ? squash_target : m_pc;
        e_resp_rdy = out_en && (dropping || (F_rdy && avail && !squash_val));
        e_f_val    = out_en && !dropping && mem_resp_val && avail && !squash_val;

        @(negedge clk);
        s_req_val  = mem_req_val;
        s_req_addr = mem_req_addr;
        s_resp_rdy = mem_resp_rdy;
        s_f_val    = F_val;
        s_f_inst   = F_inst;
        s_f_pc     = F_pc;
        s_f_seq    = F_seq_num;

        check("mem_req_val", s_req_val, e_req_val);
        if (e_req_val)
            check("mem_req_addr", s_req_addr, e_req_addr);
        check("mem_resp_rdy", s_resp_rdy, e_resp_rdy);
        check("F_val", s_f_val, e_f_val);
        if (e_f_val && m_q.size() > 0) begin
            check("F_pc", s_f_pc, m_q[0].addr);
            check("F_inst", s_f_inst, inst_of(m_q[0].addr));
            check("F_seq_num", s_f_seq, m_next);
        end

        @(posedge clk);
        if (rst) begin
            mem_q.delete();
        end else begin
            if (mem_resp_val && s_resp_rdy)
                void'(mem_q.pop_front());
            if (s_req_val && mem_req_rdy) begin
                r = cyc + $urandom_range(lat_hi, lat_lo);
                if (mem_q.size() > 0 && mem_q[$].ready > r)
                    r = mem_q[$].ready;
                mem_q.push_back('{addr: s_req_addr, ready: r});
            end
            if (s_f_val && F_rdy)
                dut_deliv++;
        end

        if (rst) begin
            model_reset();
        end else begin
            req_x  = e_req_val && mem_req_rdy;
            resp_x = mem_resp_val && e_resp_rdy;
            f_x    = e_f_val && F_rdy;
            if (resp_x && m_q.size() > 0)
                void'(m_q.pop_front());
            if (squash_val)
                foreach (m_q[i]) m_q[i].stale = 1;
            if (req_x) begin
                m_q.push_back('{addr: e_req_addr, stale: 0});
                model_acc++;
                m_pc = e_req_addr + 32'd4;
            end else if (squash_val) begin
                m_pc = squash_target;
            end
            if (f_x)
                cq.push_back(m_next);
            if (squash_val)
                m_next = (int'(squash_seq_num) + 1) % SEQ_MOD;
            else if (f_x)
                m_next = (m_next + 1) % SEQ_MOD;
            if (commit_val) begin
                m_oldest = (int'(commit_seq_num) + 1) % SEQ_MOD;
                if (auto_c)
                    void'(cq.pop_front());
            end
        end
        m_rst_q = rst;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        check("rst_req_val", s_req_val, 1'b0);
        check("rst_f_val", s_f_val, 1'b0);
        rst = 1'b0;
        cycle();
        check("post_rst_req_val", s_req_val, 1'b0);
        check("post_rst_f_val", s_f_val, 1'b0);
    endtask

    initial begin
        bit found;
        bit saw_full;

        rst = 1'b1; mem_req_rdy = 1'b1; F_rdy = 1'b1;
        squash_val = 1'b0; squash_target = '0; squash_seq_num = '0;
        commit_val = 1'b0; commit_seq_num = '0;
        mem_resp_val = 1'b0; mem_resp_data = '0;
        auto_commit = 1; commit_pct = 100; lat_lo = 1; lat_hi = 1; mem_hold = 0;
        cyc = 0; dut_deliv = 0; model_acc = 0;
        model_reset();
        m_rst_q = 1;
        @(posedge clk); #1;

        // 1: back-to-back delivery with a one-cycle memory
        do_reset();
        cycle();
        check("t1_req_val", s_req_val, 1'b1);
        check("t1_req_addr", s_req_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t1_f_val", s_f_val, 1'b1);
            check("t1_f_pc", s_f_pc, 32'h200 + 32'(4 * i));
            check("t1_f_seq", s_f_seq, i);
        end

        // 2: long latency saturates the request window, then drain
        do_reset();
        lat_lo = 5; lat_hi = 5;
        dut_deliv = 0; model_acc = 0; saw_full = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!s_req_val) saw_full = 1;
        end
        check("t2_req_throttled", saw_full, 1'b1);
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 40 && m_q.size() > 0; i++) cycle();
        check("t2_no_loss", dut_deliv, model_acc);
        mem_req_rdy = 1'b1;

        // 3: squash with three requests outstanding
        do_reset();
        lat_lo = 4; lat_hi = 4;
        repeat (3) cycle();
        auto_commit = 0;
        squash_val = 1'b1; squash_target = 32'h400; squash_seq_num = 2'd1;
        commit_val = 1'b1; commit_seq_num = 2'd1;
        cycle();
        check("t3_sq_addr", s_req_addr, 32'h400);
        check("t3_sq_f_val", s_f_val, 1'b0);
        squash_val = 1'b0; commit_val = 1'b0; auto_commit = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_drop_f_val", s_f_val, 1'b0);
            check("t3_drop_rdy", s_resp_rdy, 1'b1);
        end
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            found = s_f_val;
        end
        check("t3_found", found, 1'b1);
        check("t3_f_pc", s_f_pc, 32'h400);
        check("t3_f_seq", s_f_seq, 2'd2);

        // 4: decode back-pressure holds the presented instruction
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (2) cycle();
        F_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t4_f_val", s_f_val, 1'b1);
            check("t4_resp_rdy", s_resp_rdy, 1'b0);
            check("t4_f_pc", s_f_pc, 32'h204);
            check("t4_f_inst", s_f_inst, inst_of(32'h204));
            check("t4_f_seq", s_f_seq, 2'd1);
        end
        F_rdy = 1'b1;
        cycle();
        check("t4_release_pc", s_f_pc, 32'h204);
        check("t4_release_seq", s_f_seq, 2'd1);

        // 5: sequence space exhaustion and wrap with SB=2
        do_reset();
        auto_commit = 0; commit_val = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_seq", s_f_seq, i);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_stall", s_f_val, 1'b0);
        end
        commit_val = 1'b1; commit_seq_num = 2'd0;
        cycle();
        check("t5_commit_cycle", s_f_val, 1'b0);
        commit_val = 1'b1; commit_seq_num = 2'd1;
        cycle();
        check("t5_resume_val", s_f_val, 1'b1);
        check("t5_resume_seq", s_f_seq, 2'd3);
        commit_val = 1'b0;
        cycle();
        check("t5_wrap_val", s_f_val, 1'b1);
        check("t5_wrap_seq", s_f_seq, 2'd0);
        auto_commit = 1;

        // 6: reset with requests outstanding
        do_reset();
        lat_lo = 4; lat_hi = 4;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("t6_rst_req_val", s_req_val, 1'b0);
        check("t6_rst_f_val", s_f_val, 1'b0);
        rst = 1'b0;
        cycle();
        check("t6_post_req_val", s_req_val, 1'b0);
        check("t6_post_f_val", s_f_val, 1'b0);
        cycle();
        check("t6_req_val", s_req_val, 1'b1);
        check("t6_req_addr", s_req_addr, 32'h200);
        check("t6_f_val", s_f_val, 1'b0);

        // Randomized traffic
        do_reset();
        lat_lo = 1; lat_hi = 5; commit_pct = 70;
        for (int i = 0; i < 2000; i++) begin
            mem_req_rdy = ($urandom_range(3) != 0);
            F_rdy       = ($urandom_range(3) != 0);
            mem_hold    = ($urandom_range(7) == 0);
            squash_val  = ($urandom_range(15) == 0);
            if (squash_val) begin
                squash_target  = $urandom() & 32'hFFFF_FFFC;
                squash_seq_num = SB'((m_next + SEQ_MOD - 1) % SEQ_MOD);
            end
            cycle();
        end
        squash_val = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
